// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - two-requester round-robin write arbiter in front of a FIFO
// Bursts of up to BURST_MAX beats per grant while the other side waits.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic [1:0]        grant,
    output logic [15:0]       xfer_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    localparam logic [3:0] BEAT_FINAL = 4'(BURST_MAX - 1);

    state_t      state, state_next;
    logic [3:0]  beat, beat_next;
    logic        rr_last, rr_last_next;   // 0 = A served last, 1 = B
    logic [15:0] count;

    logic   owner_valid;
    logic   other_valid;
    logic   owner_id;
    state_t other_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            beat    <= 4'd0;
            rr_last <= 1'b1;
            count   <= 16'd0;
        end else begin
            state   <= state_next;
            beat    <= beat_next;
            rr_last <= rr_last_next;
            if (fifo_wr_en)
                count <= count + 16'd1;
        end
    end

    always_comb begin
        a_ready      = (state == GNT_A) && !fifo_full;
        b_ready      = (state == GNT_B) && !fifo_full;
        fifo_wr_en   = (a_valid && a_ready) || (b_valid && b_ready);
        fifo_wr_data = '0;
        case (state)
            GNT_A:   fifo_wr_data = a_data;
            GNT_B:   fifo_wr_data = b_data;
            default: fifo_wr_data = '0;
        endcase
    end

    assign grant      = state;
    assign xfer_count = count;

    // Owner/other view lets both grant states share one set of transition rules.
    always_comb begin
        owner_valid = (state == GNT_A) ? a_valid : b_valid;
        other_valid = (state == GNT_A) ? b_valid : a_valid;
        owner_id    = (state == GNT_B);
        other_state = (state == GNT_A) ? GNT_B : GNT_A;
    end

    always_comb begin
        state_next   = state;
        beat_next    = beat;
        rr_last_next = rr_last;
        case (state)
            IDLE: begin
                if (a_valid && (!b_valid || rr_last)) begin
                    state_next = GNT_A;
                    beat_next  = 4'd0;
                end else if (b_valid) begin
                    state_next = GNT_B;
                    beat_next  = 4'd0;
                end
            end
            GNT_A, GNT_B: begin
                if (!owner_valid) begin
                    // Owner withdrew: allowed even while the FIFO is full.
                    state_next   = other_valid ? other_state : IDLE;
                    beat_next    = 4'd0;
                    rr_last_next = owner_id;
                end else if (fifo_wr_en) begin
                    if (beat == BEAT_FINAL) begin
                        beat_next = 4'd0;
                        if (other_valid) begin
                            state_next   = other_state;
                            rr_last_next = owner_id;
                        end
                    end else begin
                        beat_next = beat + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                beat_next  = 4'd0;
            end
        endcase
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the requester and FIFO data width.
REQ-002 The module SHALL have parameter BURST_MAX, default 4, giving the maximum transfers per grant while the other requester waits (legal range 1..15).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port a_valid, input, 1 bit: requester A has data.
REQ-006 The module SHALL have port a_data, input, DATA_W bits: requester A data.
REQ-007 The module SHALL have port a_ready, output, 1 bit: A transfer accepted this cycle when a_valid is also high.
REQ-008 The module SHALL have port b_valid, input, 1 bit: requester B has data.
REQ-009 The module SHALL have port b_data, input, DATA_W bits: requester B data.
REQ-010 The module SHALL have port b_ready, output, 1 bit: B transfer accepted this cycle when b_valid is also high.
REQ-011 The module SHALL have port fifo_full, input, 1 bit: FIFO write-side full flag.
REQ-012 The module SHALL have port fifo_wr_en, output, 1 bit: FIFO write strobe.
REQ-013 The module SHALL have port fifo_wr_data, output, DATA_W bits: FIFO write data.
REQ-014 The module SHALL have port grant, output, 2 bits: one-hot owner, bit0=A, bit1=B, 00=idle.
REQ-015 The module SHALL have port xfer_count, output, 16 bits: total accepted transfers, wrapping.

Function
REQ-016 States SHALL be IDLE, GNT_A and GNT_B; grant SHALL be 00/01/10 respectively, driven from registers.
REQ-017 a_ready SHALL equal (state==GNT_A) AND NOT fifo_full; b_ready SHALL equal (state==GNT_B) AND NOT fifo_full; both combinational, never both high.
REQ-018 fifo_wr_en SHALL equal (a_valid AND a_ready) OR (b_valid AND b_ready), combinational, zero latency.
REQ-019 fifo_wr_data SHALL be a_data in GNT_A, b_data in GNT_B, all zeros in IDLE.
REQ-020 IDLE SHALL assert no ready; the first transfer of any grant SHALL occur no earlier than one cycle after valid is seen in IDLE.
REQ-021 IDLE with only A valid SHALL go to GNT_A; with only B valid SHALL go to GNT_B; with neither SHALL stay in IDLE.
REQ-022 IDLE with both valid SHALL grant the requester not recorded in the 1-bit last-served pointer (rr_last); rr_last resets to B, so A wins the first tie.
REQ-023 A 4-bit beat counter SHALL increment on each accepted transfer and SHALL clear on entering any grant state.
REQ-024 In GNT_x, if the owner drops valid: go to the other grant if the other is valid, else go to IDLE.
REQ-025 In GNT_x, on the transfer that brings beat to BURST_MAX: go to the other grant if the other is valid; otherwise stay and clear beat.
REQ-026 On every exit from GNT_x, rr_last SHALL be set to x.
REQ-027 fifo_full high SHALL stall: no transfer, beat held, no state change except the owner-drops-valid exit of REQ-024.
REQ-028 Valid dropping while full SHALL follow REQ-024; data SHALL not be lost because no transfer occurred.
REQ-029 xfer_count SHALL increment by 1 on each cycle with fifo_wr_en high and wrap from 0xFFFF to 0x0000.

Reset
REQ-030 While rst is high: state SHALL be IDLE, grant 00, beat 0, rr_last B, xfer_count 0, and a_ready, b_ready and fifo_wr_en 0, independent of clk.
REQ-031 rst asserted mid-burst SHALL abort the grant immediately with no further write; after release, arbitration SHALL restart from IDLE.

Verification
REQ-032 Bench: A alone streams 6 words 0x10..0x15, fifo_full=0 -> IDLE then GNT_A; 6 consecutive fifo_wr_en pulses carrying 0x10..0x15; xfer_count=6; IDLE one cycle after a_valid drops.
REQ-033 Bench: A and B both valid continuously, BURST_MAX=4 -> A writes 4, B writes 4, A writes 4; grant pattern 01,10,01; no gap cycles between bursts.
REQ-034 Bench: fifo_full held high for 3 cycles mid A-burst -> a_ready=0 and no writes for 3 cycles; beat preserved; burst completes with 4 total A writes.
REQ-035 Bench: B valid alone for 10 words with BURST_MAX=4 -> 10 back-to-back B writes, grant stays 10 throughout.
REQ-036 Bench: rst pulsed during the 2nd beat of a GNT_B burst -> outputs zero immediately, xfer_count=0; on release with both valid, A wins first.
REQ-037 Bench: preload xfer_count via 65535 writes, then 1 more -> xfer_count reads 0x0000.
